// File: rtl/wb_drain_pkg.sv
// wb_drain shared types and constants.
// Word width, parameter limits and reset data value.
package wb_pkg;
  localparam int WB_WIDTH  = 128;
  localparam int WL_MAX    = 15;
  localparam int BURST_MAX = 8;

  typedef logic [WB_WIDTH-1:0] wb_word_t;

  localparam wb_word_t WD_RST = '0;

  function automatic logic [3:0] cnt4(input int v);
    return v[3:0];
  endfunction
endpackage

// File: rtl/wb_drain_if.sv
// Write-buffer read port plus DDR data-path I/O.
// The drain is the slave; buffer and serializer side is the master.
interface wb_drain_if;
  import wb_pkg::*;

  wb_word_t MD;
  logic     Empty;
  logic     RDen;
  wb_word_t WrData;
  logic     DQoe;
  logic     DQSoe;

  modport master (
    output MD, Empty,
    input  RDen, WrData, DQoe, DQSoe
  );

  modport slave (
    input  MD, Empty,
    output RDen, WrData, DQoe, DQSoe
  );
endinterface

// File: rtl/wb_start_delay.sv
// N-stage start-marker shift register.
// Tap k is high k+1 cycles after the marker was entered.
module wb_start_delay #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  output logic [N-1:0] taps
);

  // shift markers one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) taps <= '0;
    else     taps <= (taps << 1) | N'(din);
  end

endmodule

// File: rtl/wb_drain.sv
// Write-data pump: write buffer -> DDR I/O.
// Delayed start markers drive pops, OE timing and completion.
module wb_drain
  import wb_pkg::*;
#(
  parameter int WL    = 4,
  parameter int BURST = 2
) (
  input  logic Rclk,
  input  logic Reset,
  input  logic WrStart,
  input  logic ClrErr,
  wb_drain_if.slave io,
  output logic WrDone,
  output logic Busy,
  output logic Underrun,
  output logic CmdErr
);

  if (WL < 2 || WL > WL_MAX ||
      BURST < 1 || BURST > BURST_MAX) begin : g_bad
    $error("wb_drain: WL/BURST out of range");
  end

  localparam logic [3:0] BL1 = cnt4(BURST - 1);

  logic [WL-1:0] dly;
  logic [3:0]    cnt;
  logic [3:0]    sp;
  logic          go;
  logic          emerge;
  logic          pre;
  logic          active;
  logic          last;

  // starts inside the spacing window are dropped
  assign go = WrStart & (sp == 4'd0);

  wb_start_delay #(.N(WL)) u_dly (
    .clk  (Rclk),
    .rst  (Reset),
    .din  (go),
    .taps (dly)
  );

  // emerging marker is the first beat; cnt holds beats still to come
  assign emerge = dly[WL-1];
  assign pre    = dly[WL-2];
  assign active = emerge | (cnt != 4'd0);
  assign last   = emerge ? (BURST == 1) : (cnt == 4'd1);

  assign io.RDen = active & ~io.Empty;
  assign Busy    = (|dly) | active | io.DQoe;

  // beat and spacing counters
  always_ff @(posedge Rclk or posedge Reset) begin
    if (Reset) begin
      cnt <= 4'd0;
      sp  <= 4'd0;
    end else begin
      if (emerge)            cnt <= BL1;
      else if (cnt != 4'd0)  cnt <= cnt - 4'd1;
      if (go)                sp  <= BL1;
      else if (sp != 4'd0)   sp  <= sp - 4'd1;
    end
  end

  // data and enables, one cycle behind the beat
  always_ff @(posedge Rclk or posedge Reset) begin
    if (Reset) begin
      io.WrData <= WD_RST;
      io.DQoe   <= 1'b0;
      io.DQSoe  <= 1'b0;
      WrDone    <= 1'b0;
    end else begin
      io.DQoe  <= active;
      io.DQSoe <= active | pre;
      WrDone   <= active & last;
      if (active)
        io.WrData <= io.Empty ? '0 : io.MD;
    end
  end

  // sticky flags; a new error beats a clear
  always_ff @(posedge Rclk or posedge Reset) begin
    if (Reset) begin
      Underrun <= 1'b0;
      CmdErr   <= 1'b0;
    end else begin
      Underrun <= (Underrun & ~ClrErr) |
                  (active & io.Empty);
      CmdErr   <= (CmdErr & ~ClrErr) |
                  (WrStart & ~go);
    end
  end

endmodule

// File: doc/wb_drain.md
Name: wb_drain

Overview:
- Write-data pump between the two-FIFO write buffer (128-bit first-word-fall-through, ECC-protected) and the DDR data-path I/O.
- The command sequencer pulses WrStart when it issues a WRITE command. WL cycles later this block pops BURST words from the write buffer and presents them to the I/O with output-enable timing.
- It also drives the DQS output-enable preamble, signals completion, and flags underrun and command-spacing violations.

Parameters:
- WL, 4, write latency in Rclk cycles from WrStart to the first pop; legal range 2..15.
- BURST, 2, 128-bit words per WRITE command; legal range 1..8.

Ports:
- Rclk  input  1  memory-side clock; same clock as the write-buffer read side.
- Reset  input  1  asynchronous, active-high.
- WrStart  input  1  one-cycle pulse, WRITE command issued.
- ClrErr  input  1  clears the sticky error flags.
- MD  input  128  write-buffer head word (FWFT, valid while !Empty).
- Empty  input  1  write buffer empty.
- RDen  output  1  pop the write buffer.
- WrData  output  128  data to the DDR output serializer.
- DQoe  output  1  DQ/DM output enable, aligned with WrData.
- DQSoe  output  1  DQS output enable, including one-cycle preamble.
- WrDone  output  1  one-cycle pulse on the last data cycle of a burst.
- Busy  output  1  any start is in flight or a burst is active.
- Underrun  output  1  sticky: a pop was required while Empty.
- CmdErr  output  1  sticky: WrStart arrived too close to the previous one.

Behaviour:
- Reset values: all outputs 0, WrData 0, delay line and counters cleared.
- Reset mid-burst aborts the burst immediately. The write buffer is not touched; it has its own Reset.
- Delay line: WL-stage shift register carrying start markers. A marker entered at cycle t (WrStart accepted) emerges at cycle t+WL.
- Beat counter: a marker emerging loads BeatCnt = BURST and sets Active. Each Active cycle decrements BeatCnt; Active clears when BeatCnt reaches 1 and decrements.
- Beat cycles are t+WL .. t+WL+BURST-1.
- RDen is combinational: RDen = Active & !Empty. No pop occurs outside beat cycles.
- Registered outputs, updated on the cycle after each beat cycle:
  - DQoe <= Active.
  - WrData <= MD when Active & !Empty; 128'h0 when Active & Empty; otherwise hold.
- Underrun is set when Active & Empty. The beat still consumes its slot: the counter advances and zeros are sent. It is sticky until ClrErr or Reset.
- DQSoe is registered:
  - high from cycle t+WL (preamble, one cycle before the first DQoe) through the last DQoe cycle t+WL+BURST;
  - low otherwise.
- WrDone is high in cycle t+WL+BURST, coincident with the final DQoe.
- Command spacing: the minimum WrStart-to-WrStart distance is BURST cycles.
  - Tracked by a spacing counter loaded with BURST-1 on an accepted start.
  - A WrStart while the counter is nonzero is dropped (no marker entered) and sets CmdErr (sticky).
- Spacing exactly BURST gives back-to-back bursts:
  - DQoe and DQSoe stay continuously high, with no second preamble gap;
  - WrDone pulses once per burst.
- If ClrErr and a new error occur in the same cycle, the error wins (the flag is set).
- Busy = (delay line nonzero) | Active | DQoe.
- Width rules: BeatCnt and the spacing counter are 4 bits; the delay line is WL bits.

Decomposition:
- Shared package wb_pkg: WB_WIDTH=128, WL_MAX=15, BURST_MAX=8, and the reset value of WrData.
- One sub-module, wb_start_delay: a parameterized WL-stage marker shift register with async reset, also reusable for the read-enable timing path.

Test Plan:
- Reset, then preload 2 words A,B and WrStart at cycle 10 (WL=4, BURST=2) -> RDen high at cycles 14,15; DQoe and WrData=A,B at 15,16; DQSoe high at 14..16; WrDone at 16.
- Two WrStarts at cycles 10 and 12 with 4 words preloaded -> DQoe continuous over 15..18, DQSoe over 14..18, WrDone at 16 and 18, CmdErr=0.
- WrStarts at cycles 10 and 11 -> second start dropped, CmdErr=1 from cycle 12, only 2 pops occur; ClrErr at 20 -> CmdErr=0 at 21.
- Preload 1 word, WrStart at 10 -> first beat WrData=A; second beat has RDen=0, WrData=0, and Underrun=1 from cycle 16; DQoe/WrDone timing unchanged.
- Reset asserted at cycle 15 mid-burst -> all outputs 0 asynchronously; after release no residual RDen/DQoe; the next WrStart behaves as in scenario 1.
- WL=2, BURST=8, WrStart at 10 with 8 words preloaded -> RDen over 12..19, DQoe over 13..20, DQSoe over 12..20, WrDone at 20.
